wb_stage_ctrl: RTL and testbench
================================

// Module: wb_stage_ctrl
// PURPOSE
// - Parametrised register-writeback stage for the RV32I core: successor to the single-cycle combinational writeback mux.
// - Selects ALU / load / PC+4 / immediate result, aligns and extends load data, waits on a variable-latency dmem response.
// - Issues one registered register-file write per accepted instruction; stalls upstream while a load is pending.
// PARAMETERS
// - XLEN         32   datapath width (32 only for RV32I; kept generic for RV64 work)
// - REGADDR_W    5    register address width
// - MEM_TIMEOUT  15   max cycles in WAIT_MEM before abort (4-bit counter minimum)
// PORTS
// - clk           in   1          clock; all state on rising edge
// - rst           in   1          synchronous, active-high reset
// - in_valid      in   1          upstream instruction valid
// - in_ready      out  1          stage can accept (0 only in WAIT_MEM)
// - wb_sel        in   2          0=ALU 1=MEM 2=PC+4 3=IMM
// - rd_we         in   1          instruction writes rd
// - rd_addr       in   REGADDR_W  destination register
// - funct3        in   3          load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
// - addr_lo       in   2          low bits of load effective address
// - alu_result    in   XLEN       ALU output
// - pc            in   XLEN       instruction PC
// - imm           in   XLEN       U-type immediate (LUI)
// - dmem_rvalid   in   1          load data valid, single-cycle pulse
// - dmem_rdata    in   XLEN       raw aligned memory word
// - rf_we         out  1          register-file write enable (registered)
// - rf_waddr      out  REGADDR_W  write address (registered)
// - rf_wdata      out  XLEN       write data (registered)
// - err           out  1          sticky: misaligned load, timeout or stray rvalid
// - byp_valid/byp_addr/byp_data  out 1/REGADDR_W/XLEN  forwarding copy of last write
// BEHAVIOUR
// - Reset: state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, err=0, timeout cnt=0, byp_*=0; in_ready=1 next cycle.
// - FSM: IDLE, WAIT_MEM, WRITE. in_ready = (state != WAIT_MEM). Accept = in_valid & in_ready.
// - Accept, wb_sel!=1: result registered; rf_we=1 the following cycle (latency 1); state=WRITE.
//   ALU->alu_result, PC+4->pc+4 (mod 2^XLEN), IMM->imm.
// - Accept, wb_sel==1: capture rd_we/rd_addr/funct3/addr_lo; state=WAIT_MEM; cnt=0.
// - WAIT_MEM: dmem_rvalid -> extract byte/half at addr_lo, sign- (LB/LH) or zero-extend (LBU/LHU), LW raw;
//   rf_we=1 next cycle, state=WRITE. rvalid in same cycle as accept is ignored (response is >=1 cycle after).
// - Misaligned (LH/LHU addr_lo[0]=1; LW addr_lo!=0): no write, err=1, return to IDLE when rvalid arrives.
// - Timeout: cnt reaches MEM_TIMEOUT without rvalid -> err=1, no write, state=IDLE.
// - WRITE: rf_we high exactly one cycle per instruction; accept in WRITE allowed (back-to-back, 1 instr/cycle
//   for non-loads); no new accept -> IDLE, rf_we=0.
// - rd_we=0 or rd_addr=0 -> rf_we stays 0 (x0 never written); timing otherwise unchanged.
// - dmem_rvalid outside WAIT_MEM: ignored for data, sets err.
// - Illegal funct3 on load: treated as LW.
// - err clears only on rst. rst mid-load: pending load dropped, no write, late rvalid after reset sets err.
// CONFIGURATION
// - WB_BYPASS_EN defined: byp_valid=rf_we, byp_addr=rf_waddr, byp_data=rf_wdata, plus a combinational
//   early path: in WAIT_MEM with rvalid, byp_* present the extended load data in the same cycle.
// - Undefined: byp_valid/byp_addr/byp_data tied to 0; ports remain present.
// STRUCTURE
// - Package rv32_wb_pkg: wb_sel_e enum (WB_ALU, WB_MEM, WB_PC4, WB_IMM), load funct3 constants, wb_state_e.
// - One sub-module load_align_ext: combinational (rdata, funct3, addr_lo) -> extended data + misalign flag.
// - FSM, timeout counter and output registers in wb_stage_ctrl.
// TESTING
// - ALU: wb_sel=0, rd=5, alu_result=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234.
// - LB: addr_lo=3, rvalid 3 cycles later rdata=0x80FF_0000 -> in_ready=0 while waiting; rf_wdata=0xFFFF_FF80.
// - LHU: addr_lo=2, rdata=0xBEEF_1234 -> rf_wdata=0x0000_BEEF; LH addr_lo=1 -> no write, err=1.
// - JAL: wb_sel=2, pc=0xFFFF_FFFC -> rf_wdata=0x0000_0000 (wrap); rd=0 variant -> rf_we stays 0.
// - Back-to-back ALU,IMM,PC4 on consecutive cycles -> three consecutive rf_we pulses, in order.
// - Load with no rvalid for 15 cycles -> err=1, IDLE, no write; rst mid-WAIT_MEM -> all outputs 0 next cycle.

Source files
------------

// File: rtl/rv32_wb_pkg.sv
// rtl/rv32_wb_pkg.sv - shared types and load constants for the RV32I writeback stage
package rv32_wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE    = 2'd2
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align_ext.sv
// rtl/load_align_ext.sv - extracts, aligns and extends load data; flags misaligned accesses
module load_align_ext
  import rv32_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata[{addr_lo, 3'b000} +: 8];
  assign half_v = rdata[{addr_lo[1], 4'b0000} +: 16];

  // Unknown funct3 values fall through to the word path.
  always_comb begin
    data     = rdata;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH: begin
        data     = {{(XLEN-16){half_v[15]}}, half_v};
        misalign = addr_lo[0];
      end
      F3_LHU: begin
        data     = {{(XLEN-16){1'b0}}, half_v};
        misalign = addr_lo[0];
      end
      F3_LW: begin
        data     = rdata;
        misalign = (addr_lo != 2'b00);
      end
      default: begin
        data     = rdata;
        misalign = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/wb_stage_ctrl.sv
// rtl/wb_stage_ctrl.sv - registered writeback stage with variable-latency load wait
// Optional forwarding outputs enabled by defining WB_BYPASS_EN.
module wb_stage_ctrl
  import rv32_wb_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REGADDR_W   = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           wb_sel,
  input  logic                 rd_we,
  input  logic [REGADDR_W-1:0] rd_addr,
  input  logic [2:0]           funct3,
  input  logic [1:0]           addr_lo,
  input  logic [XLEN-1:0]      alu_result,
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      imm,
  input  logic                 dmem_rvalid,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic                 rf_we,
  output logic [REGADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 err,
  output logic                 byp_valid,
  output logic [REGADDR_W-1:0] byp_addr,
  output logic [XLEN-1:0]      byp_data
);

  localparam int CNT_W = (MEM_TIMEOUT < 16) ? 4 : $clog2(MEM_TIMEOUT + 1);

  wb_state_e state, state_nxt;

  logic                 accept, is_load, timeout;
  logic                 ld_we;
  logic [REGADDR_W-1:0] ld_addr;
  logic [2:0]           ld_f3;
  logic [1:0]           ld_lo;
  logic [CNT_W-1:0]     cnt;
  logic [XLEN-1:0]      ld_data, wb_result;
  logic                 ld_misalign;

  load_align_ext #(.XLEN(XLEN)) u_align (
    .rdata    (dmem_rdata),
    .funct3   (ld_f3),
    .addr_lo  (ld_lo),
    .data     (ld_data),
    .misalign (ld_misalign)
  );

  assign accept  = in_valid & in_ready;
  assign is_load = (wb_sel_e'(wb_sel) == WB_MEM);
  assign timeout = (state == ST_WAIT_MEM) && !dmem_rvalid && (cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    case (wb_sel_e'(wb_sel))
      WB_PC4:  wb_result = pc + XLEN'(4);
      WB_IMM:  wb_result = imm;
      default: wb_result = alu_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT_MEM: begin
        if (dmem_rvalid)  state_nxt = ld_misalign ? ST_IDLE : ST_WRITE;
        else if (timeout) state_nxt = ST_IDLE;
      end
      default: begin
        if (accept) state_nxt = is_load ? ST_WAIT_MEM : ST_WRITE;
        else        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready = (state != ST_WAIT_MEM);
  end

  // Datapath registers: write port, captured load context, timeout counter, sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      err      <= 1'b0;
      cnt      <= '0;
      ld_we    <= 1'b0;
      ld_addr  <= '0;
      ld_f3    <= '0;
      ld_lo    <= '0;
    end else begin
      rf_we <= 1'b0;
      if (state == ST_WAIT_MEM) begin
        if (dmem_rvalid) begin
          if (ld_misalign) begin
            err <= 1'b1;
          end else if (ld_we && (ld_addr != '0)) begin
            rf_we    <= 1'b1;
            rf_waddr <= ld_addr;
            rf_wdata <= ld_data;
          end
        end else if (timeout) begin
          err <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        if (dmem_rvalid) err <= 1'b1;
        if (accept) begin
          if (is_load) begin
            ld_we   <= rd_we;
            ld_addr <= rd_addr;
            ld_f3   <= funct3;
            ld_lo   <= addr_lo;
            cnt     <= '0;
          end else if (rd_we && (rd_addr != '0)) begin
            rf_we    <= 1'b1;
            rf_waddr <= rd_addr;
            rf_wdata <= wb_result;
          end
        end
      end
    end
  end

`ifdef WB_BYPASS_EN
  logic byp_early;
  assign byp_early = (state == ST_WAIT_MEM) && dmem_rvalid && !ld_misalign &&
                     ld_we && (ld_addr != '0);
  assign byp_valid = byp_early | rf_we;
  assign byp_addr  = byp_early ? ld_addr : rf_waddr;
  assign byp_data  = byp_early ? ld_data : rf_wdata;
`else
  assign byp_valid = 1'b0;
  assign byp_addr  = '0;
  assign byp_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// tb/tb_wb_stage_ctrl.sv - self-checking bench for wb_stage_ctrl
module tb_wb_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  wb_sel;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic [31:0] alu_result, pc, imm;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        err;
  logic        byp_valid;
  logic [4:0]  byp_addr;
  logic [31:0] byp_data;

  int n_checks = 0;
  int n_fail   = 0;

  wb_stage_ctrl #(.XLEN(32), .REGADDR_W(5), .MEM_TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .wb_sel      (wb_sel),
    .rd_we       (rd_we),
    .rd_addr     (rd_addr),
    .funct3      (funct3),
    .addr_lo     (addr_lo),
    .alu_result  (alu_result),
    .pc          (pc),
    .imm         (imm),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .err         (err),
    .byp_valid   (byp_valid),
    .byp_addr    (byp_addr),
    .byp_data    (byp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pcv;
    logic [31:0] immv;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; dmem_rvalid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Accept a load, hold rvalid low for d-1 cycles (checking the stall), then pulse rvalid.
  task automatic do_load(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] rd,
                         input logic [31:0] rdata, input int d);
    @(negedge clk);
    in_valid = 1'b1; wb_sel = 2'd1; rd_we = 1'b1; rd_addr = rd; funct3 = f3; addr_lo = lo;
    @(posedge clk); #1;
    check("load_stall_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 1; i < d; i++) begin
      @(negedge clk); in_valid = 1'b0;
      @(posedge clk); #1;
      check($sformatf("load_wait_ready_%0d", i), {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'd0, 1'b1, 5'd5,  32'h0000_1234, 32'h0,         32'h0,         1'b1, 5'd5,  32'h0000_1234};
    vecs[1] = '{2'd3, 1'b1, 5'd7,  32'h0,         32'h0,         32'hDEAD_B000, 1'b1, 5'd7,  32'hDEAD_B000};
    vecs[2] = '{2'd2, 1'b1, 5'd1,  32'h0,         32'h0000_0100, 32'h0,         1'b1, 5'd1,  32'h0000_0104};
    vecs[3] = '{2'd2, 1'b1, 5'd1,  32'h0,         32'hFFFF_FFFC, 32'h0,         1'b1, 5'd1,  32'h0000_0000};
    vecs[4] = '{2'd2, 1'b1, 5'd0,  32'h0,         32'hFFFF_FFFC, 32'h0,         1'b0, 5'd0,  32'h0};
    vecs[5] = '{2'd0, 1'b0, 5'd3,  32'h0000_0055, 32'h0,         32'h0,         1'b0, 5'd0,  32'h0};
    vecs[6] = '{2'd0, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'h0,         32'h0,         1'b1, 5'd31, 32'hFFFF_FFFF};

    rst = 1'b1; in_valid = 1'b0; wb_sel = 2'd0; rd_we = 1'b0; rd_addr = 5'd0;
    funct3 = 3'd0; addr_lo = 2'd0; alu_result = 32'h0; pc = 32'h0; imm = 32'h0;
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;

    do_reset();
    check("rst_rf_we",    {31'b0, rf_we},    32'd0);
    check("rst_rf_waddr", {27'b0, rf_waddr}, 32'd0);
    check("rst_rf_wdata", rf_wdata,          32'd0);
    check("rst_err",      {31'b0, err},      32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_byp_valid",{31'b0, byp_valid},32'd0);

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1; wb_sel = vecs[i].sel; rd_we = vecs[i].we; rd_addr = vecs[i].rd;
      alu_result = vecs[i].alu; pc = vecs[i].pcv; imm = vecs[i].immv;
      @(posedge clk); #1;
      check($sformatf("vec%0d_we", i), {31'b0, rf_we}, {31'b0, vecs[i].exp_we});
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d_addr", i), {27'b0, rf_waddr}, {27'b0, vecs[i].exp_addr});
        check($sformatf("vec%0d_data", i), rf_wdata, vecs[i].exp_data);
`ifdef WB_BYPASS_EN
        check($sformatf("vec%0d_byp", i), byp_data, vecs[i].exp_data);
`else
        check($sformatf("vec%0d_byp", i), {31'b0, byp_valid}, 32'd0);
`endif
      end
      @(negedge clk); in_valid = 1'b0;
      @(posedge clk); #1;
      check($sformatf("vec%0d_pulse_end", i), {31'b0, rf_we}, 32'd0);
    end

    // Back-to-back ALU, IMM, PC4.
    @(negedge clk);
    in_valid = 1'b1; rd_we = 1'b1; wb_sel = 2'd0; rd_addr = 5'd2; alu_result = 32'h1111_0001;
    @(posedge clk); #1;
    check("b2b_alu_we",   {31'b0, rf_we}, 32'd1);
    check("b2b_alu_data", rf_wdata, 32'h1111_0001);
    @(negedge clk);
    wb_sel = 2'd3; rd_addr = 5'd3; imm = 32'h2222_0000;
    @(posedge clk); #1;
    check("b2b_imm_we",   {31'b0, rf_we}, 32'd1);
    check("b2b_imm_addr", {27'b0, rf_waddr}, 32'd3);
    check("b2b_imm_data", rf_wdata, 32'h2222_0000);
    @(negedge clk);
    wb_sel = 2'd2; rd_addr = 5'd4; pc = 32'h0000_0200;
    @(posedge clk); #1;
    check("b2b_pc4_we",   {31'b0, rf_we}, 32'd1);
    check("b2b_pc4_data", rf_wdata, 32'h0000_0204);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_end_we",   {31'b0, rf_we}, 32'd0);

    // LB at byte 3, response three cycles after accept.
    do_load(3'b000, 2'd3, 5'd9, 32'h80FF_0000, 3);
    check("lb_we",   {31'b0, rf_we}, 32'd1);
    check("lb_addr", {27'b0, rf_waddr}, 32'd9);
    check("lb_data", rf_wdata, 32'hFFFF_FF80);
    @(posedge clk); #1;
    check("lb_pulse_end", {31'b0, rf_we}, 32'd0);

    do_load(3'b101, 2'd2, 5'd10, 32'hBEEF_1234, 1);
    check("lhu_we",   {31'b0, rf_we}, 32'd1);
    check("lhu_data", rf_wdata, 32'h0000_BEEF);

    do_load(3'b010, 2'd0, 5'd11, 32'hCAFE_F00D, 2);
    check("lw_data", rf_wdata, 32'hCAFE_F00D);
    check("err_clean", {31'b0, err}, 32'd0);

    // Misaligned LH: no write, error, back to idle.
    do_load(3'b001, 2'd1, 5'd12, 32'h1234_5678, 1);
    check("lh_mis_we",    {31'b0, rf_we}, 32'd0);
    check("lh_mis_err",   {31'b0, err}, 32'd1);
    check("lh_mis_ready", {31'b0, in_ready}, 32'd1);

    // Timeout: 15 waiting cycles without rvalid.
    do_reset();
    check("to_err_cleared", {31'b0, err}, 32'd0);
    @(negedge clk);
    in_valid = 1'b1; wb_sel = 2'd1; rd_we = 1'b1; rd_addr = 5'd6; funct3 = 3'b010; addr_lo = 2'd0;
    @(posedge clk); #1;
    @(negedge clk); in_valid = 1'b0;
    for (int i = 1; i < 15; i++) begin
      @(posedge clk); #1;
    end
    check("to_ready_14", {31'b0, in_ready}, 32'd0);
    check("to_err_14",   {31'b0, err}, 32'd0);
    @(posedge clk); #1;
    check("to_err",   {31'b0, err}, 32'd1);
    check("to_ready", {31'b0, in_ready}, 32'd1);
    check("to_we",    {31'b0, rf_we}, 32'd0);

    // Reset in the middle of a pending load, then a late response.
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; wb_sel = 2'd1; rd_we = 1'b1; rd_addr = 5'd8; funct3 = 3'b010; addr_lo = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_we",    {31'b0, rf_we}, 32'd0);
    check("mid_rst_waddr", {27'b0, rf_waddr}, 32'd0);
    check("mid_rst_wdata", rf_wdata, 32'd0);
    check("mid_rst_err",   {31'b0, err}, 32'd0);
    check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk); dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    check("late_rvalid_err", {31'b0, err}, 32'd1);
    check("late_rvalid_we",  {31'b0, rf_we}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
